// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM state codes and default widths for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned DW_DEF = 64;
    localparam int unsigned AW_DEF = 5;
    localparam int unsigned XZR    = 31;

    typedef enum logic [2:0] {
        OP_MUL   = 3'd0,
        OP_SMULH = 3'd1,
        OP_UMULH = 3'd2,
        OP_SDIV  = 3'd3,
        OP_UDIV  = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_unit_udiv_step.sv
// One combinational restoring-division iteration; present only when MULDIV_DIV_EN is defined.
`ifdef MULDIV_DIV_EN
module udiv_step #(
    parameter int unsigned DW = 64
) (
    input  logic [DW-1:0] rem_i,
    input  logic [DW-1:0] quo_i,
    input  logic [DW-1:0] div_i,
    output logic [DW-1:0] rem_o,
    output logic [DW-1:0] quo_o
);

    logic [DW:0] shifted;
    logic [DW:0] diff;

    // Remainder stays below the divisor, so the trial difference fits in DW+1 bits.
    always_comb begin
        shifted = {rem_i, quo_i[DW-1]};
        diff    = shifted - {1'b0, div_i};
        if (diff[DW]) begin
            rem_o = shifted[DW-1:0];
            quo_o = {quo_i[DW-2:0], 1'b0};
        end else begin
            rem_o = diff[DW-1:0];
            quo_o = {quo_i[DW-2:0], 1'b1};
        end
    end

endmodule
`endif

// File: rtl/muldiv_unit.sv
// Radix-2 iterative MUL/SMULH/UMULH/SDIV/UDIV unit, one result bit per cycle.
// MULDIV_DIV_EN enables the divider; without it SDIV/UDIV return 0 like illegal ops.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [AW-1:0] rd,
    input  logic          flush,
    output logic          busy,
    output logic          wb_valid,
    output logic [AW-1:0] wb_rd,
    output logic [DW-1:0] wb_data
);

    localparam int unsigned CW = $clog2(DW);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    op_q, op_d;
    logic          neg_q, neg_d;
    logic [DW-1:0] opnd_q, opnd_d;
    logic [DW-1:0] hi_q, hi_d;
    logic [DW-1:0] lo_q, lo_d;
    logic [DW-1:0] res_q, res_d;
    logic [AW-1:0] rd_q, rd_d;
    logic          busy_q, busy_d;
    logic          wb_valid_q, wb_valid_d;
    logic [AW-1:0] wb_rd_q, wb_rd_d;
    logic [DW-1:0] wb_data_q, wb_data_d;

    logic          accept, is_mul, signed_op;
    logic [DW:0]   mul_sum;
    logic [DW-1:0] mul_hi, mul_lo, fin, a_mag, b_mag;

`ifdef MULDIV_DIV_EN
    logic [DW-1:0] rem_q, rem_d;
    logic          bz_q, bz_d;
    logic          is_div;
    logic [DW-1:0] div_rem, div_quo;

    udiv_step #(.DW(DW)) u_udiv_step (
        .rem_i (rem_q),
        .quo_i (lo_q),
        .div_i (opnd_q),
        .rem_o (div_rem),
        .quo_o (div_quo)
    );

    assign is_div = (op_q == OP_SDIV) || (op_q == OP_UDIV);
`endif

    assign is_mul    = (op_q == OP_MUL) || (op_q == OP_SMULH) || (op_q == OP_UMULH);
    assign signed_op = (op == OP_SMULH) || (op == OP_SDIV);
    assign a_mag     = (signed_op && a[DW-1]) ? -a : a;
    assign b_mag     = (signed_op && b[DW-1]) ? -b : b;

    // Shift-add step: {hi,lo} holds partial product over the remaining multiplier bits.
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_hi  = mul_sum[DW:1];
        mul_lo  = {mul_sum[0], lo_q[DW-1:1]};
    end

    // Sign fix-up on the last step; high half of -P is ~hi plus carry when lo is zero.
    always_comb begin
        fin = '0;
        case (op_q)
            OP_MUL:   fin = mul_lo;
            OP_SMULH: fin = neg_q ? (~mul_hi + DW'(mul_lo == '0)) : mul_hi;
            OP_UMULH: fin = mul_hi;
`ifdef MULDIV_DIV_EN
            OP_SDIV:  fin = bz_q ? '0 : (neg_q ? -div_quo : div_quo);
            OP_UDIV:  fin = bz_q ? '0 : div_quo;
`endif
            default:  fin = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        neg_d      = neg_q;
        opnd_d     = opnd_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        res_d      = res_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
`ifdef MULDIV_DIV_EN
        rem_d      = rem_q;
        bz_d       = bz_q;
`endif
        accept     = 1'b0;

        case (state_q)
            S_IDLE: accept = start && !flush;
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    if (is_mul) begin
                        hi_d = mul_hi;
                        lo_d = mul_lo;
                    end
`ifdef MULDIV_DIV_EN
                    else if (is_div) begin
                        rem_d = div_rem;
                        lo_d  = div_quo;
                    end
`endif
                    if (cnt_q == '0) begin
                        res_d   = fin;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            S_DONE: begin
                wb_valid_d = 1'b1;
                wb_rd_d    = rd_q;
                wb_data_d  = res_q;
                state_d    = S_IDLE;
                accept     = start && !flush;
            end
            default: state_d = S_IDLE;
        endcase

        // Capture operands as magnitudes; the sign is reapplied after the last step.
        if (accept) begin
            state_d = S_RUN;
            cnt_d   = CW'(DW - 1);
            op_d    = op;
            neg_d   = signed_op && (a[DW-1] ^ b[DW-1]);
            lo_d    = a_mag;
            opnd_d  = b_mag;
            hi_d    = '0;
            rd_d    = rd;
`ifdef MULDIV_DIV_EN
            rem_d   = '0;
            bz_d    = (b == '0);
`endif
        end

        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            neg_q      <= 1'b0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            res_q      <= '0;
            rd_q       <= '0;
            busy_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
`ifdef MULDIV_DIV_EN
            rem_q      <= '0;
            bz_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            neg_q      <= neg_d;
            opnd_q     <= opnd_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            res_q      <= res_d;
            rd_q       <= rd_d;
            busy_q     <= busy_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
`ifdef MULDIV_DIV_EN
            rem_q      <= rem_d;
            bz_q       <= bz_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: per-cycle compare against a timing/arithmetic model plus directed literal cases.
module tb_muldiv_unit;

    localparam int unsigned DW  = 64;
    localparam int unsigned AW  = 5;
    localparam int          LAT = 65;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    op = '0;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = '0;
    logic [AW-1:0] rd = '0;
    logic          flush = 1'b0;
    logic          busy, wb_valid;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_unit #(.DW(DW), .AW(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .rd       (rd),
        .flush    (flush),
        .busy     (busy),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result straight from the arithmetic definitions.
    function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
        logic signed [127:0] sp;
        logic [127:0]        up;
        logic signed [63:0]  q;
        case (o)
            3'd0: return x * y;
            3'd1: begin
                sp = $signed({{64{x[63]}}, x}) * $signed({{64{y[63]}}, y});
                return sp[127:64];
            end
            3'd2: begin
                up = {64'd0, x} * {64'd0, y};
                return up[127:64];
            end
            3'd3: begin
                if (!DIV_EN || y == 64'd0) return 64'd0;
                if (x == MIN64 && y == '1) return MIN64;
                q = $signed(x) / $signed(y);
                return q;
            end
            3'd4: begin
                if (!DIV_EN || y == 64'd0) return 64'd0;
                return x / y;
            end
            default: return 64'd0;
        endcase
    endfunction

    // Expected interface state: job age counts edges since the accepting edge.
    logic          m_busy = 1'b0, m_wbv = 1'b0, job_act = 1'b0;
    int            job_age = 0;
    logic [63:0]   job_res = '0, m_wb_data = '0;
    logic [AW-1:0] job_rd = '0, m_wb_rd = '0;

    always @(posedge clk or negedge reset) begin : model
        logic acc, act, wbv;
        int   age;
        if (!reset) begin
            job_act <= 1'b0; job_age <= 0; m_busy <= 1'b0;
            m_wbv <= 1'b0; m_wb_rd <= '0; m_wb_data <= '0;
        end else begin
            acc = start && !flush && !m_busy;
            act = job_act;
            age = job_age;
            wbv = 1'b0;
            if (act) begin
                age++;
                if (flush && age <= DW) act = 1'b0;
                else if (age == DW + 1) begin
                    wbv = 1'b1;
                    act = 1'b0;
                    m_wb_rd   <= job_rd;
                    m_wb_data <= job_res;
                end
            end
            if (acc) begin
                act = 1'b1;
                age = 0;
                job_res <= ref_res(op, a, b);
                job_rd  <= rd;
            end
            job_act <= act;
            job_age <= age;
            m_wbv   <= wbv;
            m_busy  <= act && (age < DW);
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            check("cyc_busy", 64'(busy), 64'(m_busy));
            check("cyc_wb_valid", 64'(wb_valid), 64'(m_wbv));
            check("cyc_wb_rd", 64'(wb_rd), 64'(m_wb_rd));
            check("cyc_wb_data", wb_data, m_wb_data);
        end
    end

    task automatic issue(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y, input logic [AW-1:0] r);
        start = 1'b1; op = o; a = x; b = y; rd = r;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_wb(input string name, output int lat);
        lat = 0;
        while (!wb_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!wb_valid) check({name, "_timeout"}, 64'(wb_valid), 64'd1);
    endtask

    task automatic run_lit(input string name, input logic [2:0] o, input logic [63:0] x,
                           input logic [63:0] y, input logic [AW-1:0] r, input logic [63:0] exp);
        int lat;
        issue(o, x, y, r);
        wait_wb(name, lat);
        check({name, "_data"}, wb_data, exp);
        check({name, "_rd"}, 64'(wb_rd), 64'(r));
        check({name, "_lat"}, 64'(lat), 64'(LAT));
        @(negedge clk);
    endtask

    task automatic count_pulses(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (wb_valid) n++;
        end
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 6))
            0: return 64'd0;
            1: return 64'd1;
            2: return '1;
            3: return MIN64;
            4: return 64'($urandom_range(0, 20));
            5: return -64'($urandom_range(1, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin : main
        int lat, np;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_wb_rd", 64'(wb_rd), 64'd0);
        check("rst_wb_data", wb_data, 64'd0);
        check("model_smulh", ref_res(3'd1, -64'd2, 64'd3), 64'hFFFF_FFFF_FFFF_FFFF);
        check("model_sdiv", ref_res(3'd3, -64'd7, 64'd2), DIV_EN ? 64'hFFFF_FFFF_FFFF_FFFD : 64'd0);
        reset = 1'b1;
        @(negedge clk);

        run_lit("mul", 3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd4, 64'hFFFF_FFFF_FFFF_FFEB);
        run_lit("smulh", 3'd1, -64'd2, 64'd3, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF);
        run_lit("umulh", 3'd2, MIN64, 64'd4, 5'd6, 64'd2);
        run_lit("sdiv", 3'd3, -64'd7, 64'd2, 5'd7, DIV_EN ? 64'hFFFF_FFFF_FFFF_FFFD : 64'd0);
        run_lit("udiv", 3'd4, 64'd100, 64'd7, 5'd8, DIV_EN ? 64'd14 : 64'd0);
        run_lit("sdiv_ovf", 3'd3, MIN64, '1, 5'd9, DIV_EN ? MIN64 : 64'd0);
        run_lit("udiv_zero", 3'd4, 64'd55, 64'd0, 5'd10, 64'd0);
        run_lit("illegal", 3'd6, 64'd3, 64'd3, 5'd31, 64'd0);

        // Start while busy is ignored; start in the wb_valid cycle is accepted.
        issue(3'd0, 64'd5, 64'd6, 5'd1);
        repeat (10) @(negedge clk);
        start = 1'b1; op = 3'd2; rd = 5'd2;
        @(negedge clk);
        start = 1'b0;
        wait_wb("ign", lat);
        check("ign_rd", 64'(wb_rd), 64'd1);
        check("ign_data", wb_data, 64'd30);
        issue(3'd0, 64'd9, 64'd9, 5'd3);
        wait_wb("b2b", lat);
        check("b2b_lat", 64'(lat), 64'(LAT));
        check("b2b_data", wb_data, 64'd81);
        check("b2b_rd", 64'(wb_rd), 64'd3);
        count_pulses(80, np);
        check("ign_no_extra", 64'(np), 64'd0);

        issue(3'd0, 64'd11, 64'd11, 5'd12);
        repeat (19) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        count_pulses(80, np);
        check("flush_no_wb", 64'(np), 64'd0);

        issue(3'd0, 64'd13, 64'd13, 5'd13);
        repeat (29) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_wb_valid", 64'(wb_valid), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        count_pulses(80, np);
        check("arst_no_wb", 64'(np), 64'd0);
        run_lit("after_rst", 3'd4, 64'd100, 64'd7, 5'd14, DIV_EN ? 64'd14 : 64'd0);

        repeat (12000) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            op    = 3'($urandom_range(0, 7));
            a     = rnd64();
            b     = rnd64();
            rd    = 5'($urandom);
            flush = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        repeat (80) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
